// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
// Shared types and constants for the SoC system-bus arbiters.
// Contents:
//   bus_state_e    - arbiter ownership state (IDLE / BUSY)
//   master_idx_t   - index of a bus master (0 = CPU, 1 = UART loader)
//   BUS_ADDR_WIDTH - default system-bus address width
//   BUS_DATA_WIDTH - default system-bus data width
//   BUS_ERR_DATA   - read data handed back when a transaction times out
package soc_bus_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  typedef logic master_idx_t;

endpackage : soc_bus_pkg

// File: rtl/rr_pick2.sv
// rr_pick2
// Purely combinational two-way round-robin picker.
// Ports:
//   req        in  [1:0] request vector, bit N = master N
//   last_grant in  1     master that owned the bus most recently
//   pick       out [1:0] one-hot winner, 2'b00 when nobody requests
module rr_pick2
  import soc_bus_pkg::*;
(
  input  logic [1:0]  req,
  input  master_idx_t last_grant,
  output logic [1:0]  pick
);

  // A lone requester always wins. On a tie the master that did not
  // own the bus last time goes first, which gives strict alternation
  // when both masters keep requesting.
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = (last_grant == 1'b1) ? 2'b01 : 2'b10;
    end
  end

endmodule : rr_pick2

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter
// Two-master, one-slave arbiter for the SoC system bus. Master 0 is the
// CPU load/store port, master 1 the UART debug/boot loader. One
// transaction is forwarded at a time; a transaction the slave never
// acknowledges is terminated with an error after TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m0_* / m1_*         master request side (req/we/addr/wdata/wstrb in,
//                       rdata/ack/err out)
//   s_*                 slave side (req/we/addr/wdata/wstrb out,
//                       rdata/ack in)
//   grant               one-hot current owner, 2'b00 when idle
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(BUS_ERR_DATA)
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_ack,
  output logic                    m0_err,

  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_ack,
  output logic                    m1_err,

  output logic                    s_req,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_ack,

  output logic [1:0]              grant
);

  // A zero timeout disables the counter; keep it one bit wide so the
  // declaration stays legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  bus_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  master_idx_t       lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [1:0]        pick;
  logic              expire;
  logic              done;

  rr_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (lastGrant_q),
    .pick       (pick)
  );

  // The transaction expires on its last allowed BUSY cycle, and only if
  // the slave did not answer in that very cycle: a late ack still wins.
  always_comb begin
    expire = 1'b0;
    if ((TIMEOUT_CYCLES > 0) && (state_q == BUSY) && !s_ack &&
        (count_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      expire = 1'b1;
    end
  end

  assign done = (state_q == BUSY) && (s_ack || expire);

  // State register. lastGrant resets to master 1 so master 0 wins the
  // first tie after reset. Reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      lastGrant_q <= 1'b1;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a master
  // that keeps req high after its ack is simply re-arbitrated, and an
  // owner dropping req mid-transaction has no effect. The counter
  // saturates rather than wrapping.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (pick != 2'b00) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (done) begin
          state_d     = IDLE;
          grant_d     = 2'b00;
          lastGrant_d = grant_q[1];
          count_d     = '0;
        end else if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Output logic. Everything is zero outside BUSY. While BUSY the slave
  // fields follow the owner combinationally, and completion (ack or
  // timeout) is passed straight back to the owner in the same cycle.
  always_comb begin
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    if (state_q == BUSY) begin
      s_req = 1'b1;
      if (grant_q[1]) begin
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
        if (done) begin
          m1_ack   = 1'b1;
          m1_err   = expire;
          m1_rdata = s_ack ? s_rdata : ERR_DATA;
        end
      end else begin
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
        if (done) begin
          m0_ack   = 1'b1;
          m0_err   = expire;
          m0_rdata = s_ack ? s_rdata : ERR_DATA;
        end
      end
    end
  end

  assign grant = grant_q;

endmodule : soc_bus_arbiter

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
Two-master, one-slave arbiter for the SoC system bus (memory, LEDs, UART, GPIO decode). Master 0 is the CPU load/store port. Master 1 is the UART debug/boot loader. The block grants the shared bus round-robin, forwards one transaction at a time, and terminates hung transactions with an error after a programmable timeout.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, max BUSY cycles without s_ack before error termination; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request; held until m0_ack
m0_we  in  1  master 0 write enable
m0_addr  in  ADDR_WIDTH  master 0 address
m0_wdata  in  DATA_WIDTH  master 0 write data
m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes
m0_rdata  out  DATA_WIDTH  master 0 read data, valid with m0_ack
m0_ack  out  1  master 0 one-cycle completion pulse
m0_err  out  1  master 0 timeout flag, valid with m0_ack
m1_*  same set as m0_* for master 1
s_req  out  1  slave request
s_we  out  1  slave write enable
s_addr  out  ADDR_WIDTH  slave address
s_wdata  out  DATA_WIDTH  slave write data
s_wstrb  out  DATA_WIDTH/8  slave byte strobes
s_rdata  in  DATA_WIDTH  slave read data, valid with s_ack
s_ack  in  1  slave one-cycle completion
grant  out  2  one-hot current owner, for debug; 0 when IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=2'b00, last_grant=1 so master 0 wins the first tie, timeout counter=0.
  - All outputs are 0, including s_req, m*_ack, m*_err, m*_rdata, s_* fields.
  - An in-flight transaction is abandoned; s_req falls immediately, with no ack to either master.
- States:
  - IDLE: no owner; s_req=0.
  - BUSY: owner is held in grant.
- IDLE -> BUSY:
  - Triggered on any mN_req=1 at a clock edge.
  - Only one requester: it wins.
  - Both requesting: the master other than last_grant wins.
  - grant is registered at that edge.
- In BUSY:
  - s_req=1.
  - s_we/s_addr/s_wdata/s_wstrb are combinationally muxed from the granted master.
  - The non-granted master's ack/err/rdata stay 0.
- Completion (s_ack=1 in BUSY):
  - Granted mN_ack=1 and mN_rdata=s_rdata in the same cycle (combinational pass-through).
  - Next edge: state=IDLE, last_grant=owner, counter cleared.
- Latency:
  - Request first sampled at edge N → s_req high in cycle N+1.
  - Zero-wait slave → ack in cycle N+1, IDLE in N+2.
  - So there is one idle arbitration cycle between back-to-back transactions.
- Back-to-back:
  - A master keeping req high after its ack is a new request and is re-arbitrated in IDLE.
  - With both requesting continuously, grants alternate 0,1,0,1.
- Timeout:
  - Counter increments each BUSY cycle without s_ack.
  - When counter == TIMEOUT_CYCLES-1 and s_ack=0: mN_ack=1, mN_err=1, mN_rdata=ERR_DATA for that cycle; s_req drops at the next edge (return to IDLE).
  - s_ack in the same cycle as expiry wins: normal ack, err=0.
- Protocol violation (owner drops req while BUSY): ignored; s_req stays high until s_ack or timeout.
- s_ack while IDLE: ignored; no master ack.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Shared package soc_bus_pkg holds:
  - state enum {IDLE, BUSY};
  - BUS_ADDR_WIDTH/BUS_DATA_WIDTH constants;
  - ERR_DATA default;
  - master-index typedef.
- One sub-module, rr_pick2: inputs req[1:0] and last_grant; output one-hot pick. It is purely combinational and reused by the future peripheral-bus arbiter.

Test Plan:
- Reset mid-transaction: m0 read granted, slave stalls, pull rst_n low for 1 cycle → s_req falls asynchronously, m0_ack never pulses, grant=00 after release.
- Single master read, zero-wait: m0_req at edge 0, slave acks in cycle 1 with s_rdata=0x1234_5678 → m0_ack=1 and m0_rdata=0x1234_5678 in cycle 1, s_req=0 in cycle 2.
- Simultaneous requests after reset: m0_req=m1_req=1 at edge 0 → grant=01 first; slave acks each transaction after 2 wait cycles; keep both requesting → grant order 01,10,01,10 over 4 transactions.
- Write pass-through: m1 writes addr 0x0000_1004, wdata 0xA5A5_A5A5, wstrb 0x3 → s_we=1, s_addr/s_wdata/s_wstrb match exactly while BUSY; m0 outputs stay 0.
- Timeout: TIMEOUT_CYCLES=4, slave never acks → m0_ack=1, m0_err=1, m0_rdata=0xDEAD_BEEF exactly 4 cycles after s_req rises; state IDLE next cycle.
- Ack at expiry: TIMEOUT_CYCLES=4, s_ack in the 4th BUSY cycle with s_rdata=0x0000_00FF → m0_ack=1, m0_err=0, m0_rdata=0x0000_00FF.
